adder_scheduler: RTL and testbench

ADDER_SCHEDULER -- requirements
Module: adder_scheduler

---
 rtl/adder_scheduler.sv | 129 ++++++++++++
 tb/tb_adder_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_scheduler.sv
// Two-requester round-robin scheduler feeding a shared 24-bit carry-select adder through an OP/RES pipeline.
// Optional macro ADDER_SCHED_COUT_EN registers the carry out of bit 23 onto rsp_cout.
module adder_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [23:0] req0_a,
  input  logic [23:0] req0_b,
  input  logic [23:0] req1_a,
  input  logic [23:0] req1_b,
  output logic [23:0] add_a,
  output logic [23:0] add_b,
  output logic [5:0]  add_cin,
  input  logic [23:0] add_sum,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_sum,
  output logic        rsp_id,
  output logic        rsp_cout
);

  typedef enum logic [1:0] {EMPTY, OP_ONLY, RES_ONLY, BOTH} state_t;

  state_t      state_reg, state_next;
  logic [23:0] op_a_reg, op_b_reg;
  logic        op_id_reg;
  logic [23:0] res_sum_reg;
  logic        res_id_reg;
  logic        last_grant_reg;

  logic op_full, res_full, advance, drain, can_accept;
  logic grant0, grant1, accept;

  assign op_full    = (state_reg == OP_ONLY) || (state_reg == BOTH);
  assign res_full   = (state_reg == RES_ONLY) || (state_reg == BOTH);
  assign advance    = op_full && (!res_full || rsp_ready);
  assign drain      = res_full && rsp_ready;
  assign can_accept = !op_full || advance;

  // Under contention the requester not granted last wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant_reg);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_reg);

  assign req0_ready = !rst && grant0 && can_accept;
  assign req1_ready = !rst && grant1 && can_accept;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:    if (accept) state_next = OP_ONLY;
      // OP always advances here; a simultaneous accept leaves both stages full.
      OP_ONLY:  state_next = accept ? BOTH : RES_ONLY;
      RES_ONLY: begin
        if (accept && drain) state_next = OP_ONLY;
        else if (accept)     state_next = BOTH;
        else if (drain)      state_next = EMPTY;
      end
      BOTH:     if (drain && !accept) state_next = RES_ONLY;
      default:  state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= EMPTY;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_id_reg      <= 1'b0;
      res_sum_reg    <= '0;
      res_id_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_a_reg       <= req1_ready ? req1_a : req0_a;
        op_b_reg       <= req1_ready ? req1_b : req0_b;
        op_id_reg      <= req1_ready;
        last_grant_reg <= req1_ready;
      end
      if (advance) begin
        res_sum_reg <= add_sum;
        res_id_reg  <= op_id_reg;
      end
    end
  end

  // Group generate/propagate from the OP pair, rippled into per-group carry-selects.
  logic [4:0] grp_gen, grp_prop;
  logic [5:0] carry;
  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_grp
      logic [4:0] grp_raw;
      assign grp_raw       = {1'b0, op_a_reg[4*gi +: 4]} + {1'b0, op_b_reg[4*gi +: 4]};
      assign grp_gen[gi]   = grp_raw[4];
      assign grp_prop[gi]  = (grp_raw[3:0] == 4'hF);
      assign carry[gi + 1] = grp_gen[gi] | (grp_prop[gi] & carry[gi]);
    end
  endgenerate

  assign add_a     = op_a_reg;
  assign add_b     = op_b_reg;
  assign add_cin   = carry;
  assign rsp_valid = res_full;
  assign rsp_sum   = res_sum_reg;
  assign rsp_id    = res_id_reg;

`ifdef ADDER_SCHED_COUT_EN
  logic [4:0] top_raw;
  logic       cout_next;
  logic       res_cout_reg;
  assign top_raw   = {1'b0, op_a_reg[23:20]} + {1'b0, op_b_reg[23:20]};
  assign cout_next = top_raw[4] | ((top_raw[3:0] == 4'hF) & carry[5]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          res_cout_reg <= 1'b0;
    else if (advance) res_cout_reg <= cout_next;
  end
  assign rsp_cout = res_cout_reg;
`else
  assign rsp_cout = 1'b0;
`endif

endmodule

// File: tb/tb_adder_scheduler.sv
// Bench for adder_scheduler: models the shared select adder and checks against an arithmetic/queue reference.
module tb_adder_scheduler;

  logic        clk, rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [23:0] req0_a, req0_b, req1_a, req1_b;
  logic [23:0] add_a, add_b, add_sum, rsp_sum;
  logic [5:0]  add_cin;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;

  adder_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id), .rsp_cout(rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared select adder: each 4-bit group adds its own carry-select.
  always_comb begin
    add_sum = '0;
    for (int i = 0; i < 6; i++)
      add_sum[4*i +: 4] = add_a[4*i +: 4] + add_b[4*i +: 4] + {3'b000, add_cin[i]};
  end

  typedef struct { logic [23:0] sum; logic id; logic cout; } rsp_t;

  int   total = 0, bad = 0;
  rsp_t exp_q[$];
  int   grant_log[$];
  logic exp_last = 1'b1;
  bit   op_check = 0, hold_prev = 0;
  logic [23:0] last_a, last_b;
  int   acc_cnt = 0, rsp_cnt = 0, run = 0, max_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Carry into group i is the carry out of the low 4*i bits of a+b.
  function automatic logic [5:0] ref_cin(input logic [23:0] a, input logic [23:0] b);
    logic [31:0] mask, low;
    ref_cin = '0;
    for (int i = 1; i < 6; i++) begin
      mask = (32'd1 << (4*i)) - 32'd1;
      low  = ({8'd0, a} & mask) + ({8'd0, b} & mask);
      ref_cin[i] = low[4*i];
    end
  endfunction

  function automatic rsp_t ref_rsp(input logic [23:0] a, input logic [23:0] b, input logic id);
    logic [24:0] full;
    full = {1'b0, a} + {1'b0, b};
    ref_rsp.sum = full[23:0];
    ref_rsp.id  = id;
`ifdef ADDER_SCHED_COUT_EN
    ref_rsp.cout = full[24];
`else
    ref_rsp.cout = 1'b0;
`endif
  endfunction

  // One clock: check combinational outputs before the edge, update the model, advance to next negedge.
  task automatic cyc();
    bit   anyv, cap;
    int   g;
    rsp_t e;
    logic id;
    #1;
    anyv = req0_valid || req1_valid;
    g    = (req0_valid && req1_valid) ? (exp_last ? 0 : 1) : (req1_valid ? 1 : 0);
    cap  = (exp_q.size() < 2) || rsp_ready;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, anyv && cap && g == 0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, anyv && cap && g == 1});
    if (op_check) begin
      chk("add_a", add_a, last_a);
      chk("add_b", add_b, last_b);
      chk("add_cin", add_cin, ref_cin(last_a, last_b));
    end
    if (hold_prev) chk("rsp_hold", {31'd0, rsp_valid}, 32'd1);
    if (rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_spurious", {31'd0, rsp_valid}, 32'd0);
      else begin
        e = exp_q[0];
        chk("rsp_sum", rsp_sum, e.sum);
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, e.cout});
        if (rsp_ready) begin
          $display("rsp id=%0d sum=%h cout=%0d", rsp_id, rsp_sum, rsp_cout);
          void'(exp_q.pop_front());
        end
      end
    end
    if (rsp_valid && rsp_ready) begin
      rsp_cnt++; run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    hold_prev = rsp_valid && !rsp_ready;
    op_check  = 0;
    if (req0_ready || req1_ready) begin
      id     = req1_ready;
      last_a = id ? req1_a : req0_a;
      last_b = id ? req1_b : req0_b;
      exp_q.push_back(ref_rsp(last_a, last_b, id));
      grant_log.push_back(int'(id));
      exp_last = id;
      op_check = 1;
      acc_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    if (op_check) begin
      if (exp_last) begin req1_a = $urandom; req1_b = $urandom; end
      else          begin req0_a = $urandom; req0_b = $urandom; end
    end
  endtask

  task automatic drain();
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cyc();
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, r0;
    rst = 1; req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    req0_a = 24'h123456; req0_b = 24'h654321; req1_a = 24'h0F0F0F; req1_b = 24'h111111;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp_sum", rsp_sum, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_rsp_cout", {31'd0, rsp_cout}, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    @(negedge clk);
    rst = 0; req0_valid = 0; req1_valid = 0;

    // Single req0 pair: latency and group carries.
    req0_valid = 1; req0_a = 24'h000001; req0_b = 24'h00000F;
    cyc();
    req0_valid = 0;
    chk("lat_edge1", {31'd0, rsp_valid}, 32'd0);
    chk("cin_low", add_cin, 32'b000010);
    cyc();
    chk("lat_edge2", {31'd0, rsp_valid}, 32'd1);
    chk("sum_low", rsp_sum, 32'h000010);
    chk("id_low", {31'd0, rsp_id}, 32'd0);
    drain();

    // Full-width ripple from req1.
    req1_valid = 1; req1_a = 24'hFFFFFF; req1_b = 24'h000001;
    cyc();
    req1_valid = 0;
    chk("cin_ripple", add_cin, 32'b111110);
    cyc();
    chk("sum_ripple", rsp_sum, 32'h000000);
    chk("id_ripple", {31'd0, rsp_id}, 32'd1);
`ifdef ADDER_SCHED_COUT_EN
    chk("cout_ripple", {31'd0, rsp_cout}, 32'd1);
`else
    chk("cout_ripple", {31'd0, rsp_cout}, 32'd0);
`endif
    drain();

    // Contention: alternating grants starting with req0.
    grant_log.delete();
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    repeat (4) cyc();
    chk("rr_count", grant_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("rr_order", grant_log[i], i % 2);
    drain();

    // Back-pressure: only two pairs fit while the consumer stalls.
    a0 = acc_cnt;
    req0_valid = 1; rsp_ready = 0;
    repeat (5) cyc();
    chk("stall_accepts", acc_cnt - a0, 32'd2);
    chk("stall_ready_low", {31'd0, req0_ready}, 32'd0);
    drain();

    // Reset with both stages full.
    req0_valid = 1; rsp_ready = 0;
    repeat (2) cyc();
    req1_valid = 1;
    rst = 1;
    #1;
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("mid_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    exp_q.delete(); exp_last = 1; hold_prev = 0; op_check = 0;
    @(negedge clk);
    rst = 0; rsp_ready = 1;
    grant_log.delete();
    cyc();
    chk("post_rst_grant", grant_log.size() > 0 ? grant_log[0] : -1, 32'd0);
    drain();

    // req1 streaming 8 pairs at full throughput.
    a0 = acc_cnt; r0 = rsp_cnt; max_run = 0;
    req1_valid = 1; rsp_ready = 1;
    for (int k = 0; k < 20; k++) begin
      if (acc_cnt - a0 >= 8) req1_valid = 0;
      cyc();
    end
    chk("stream_accepts", acc_cnt - a0, 32'd8);
    chk("stream_rsps", rsp_cnt - r0, 32'd8);
    chk("stream_consecutive", max_run, 32'd8);

    // Random traffic and back-pressure.
    for (int k = 0; k < 300; k++) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      rsp_ready  = ($urandom_range(0, 99) < 70);
      cyc();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
